// File: rtl/tt_um_kb2ghz_xalu_seq_pkg.sv
// Purpose: shared constants and types for the nibble-serial 16-bit ALU sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package tt_um_kb2ghz_xalu_seq_pkg;

    // ALU function codes (command byte bits [2:0])
    localparam logic [2:0] F_ADD   = 3'd0;
    localparam logic [2:0] F_AND   = 3'd1;
    localparam logic [2:0] F_OR    = 3'd2;
    localparam logic [2:0] F_XOR   = 3'd3;
    localparam logic [2:0] F_PASSA = 3'd4;
    localparam logic [2:0] F_PASSB = 3'd5;
    localparam logic [2:0] F_SHR   = 3'd6;
    localparam logic [2:0] F_SHL   = 3'd7;

    // Operand byte write addresses
    localparam logic [1:0] WA_A_LO = 2'd0;
    localparam logic [1:0] WA_A_HI = 2'd1;
    localparam logic [1:0] WA_B_LO = 2'd2;
    localparam logic [1:0] WA_B_HI = 2'd3;

    // Number of 4-bit passes needed for a 16-bit operation
    localparam int NIBBLES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Command fields captured on an accepted start
    typedef struct packed {
        logic [2:0] f;
        logic       com;
        logic       cin;
    } cmd_t;

endpackage

// File: rtl/tt_um_kb2ghz_xalu_seq_alu_slice4.sv
// Purpose: 4-bit ALU slice with left/right carry ports for chaining nibbles.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a/b nibbles, f opcode, com (invert result), ci_left/ci_right carry-ins;
//        d result, co_left/co_right carry-outs, equ (a==b), zero (d==0),
//        neg_zero (d all ones, i.e. zero once inverted).
module alu_slice4
    import tt_um_kb2ghz_xalu_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] f,
    input  logic       com,
    input  logic       ci_left,
    input  logic       ci_right,
    output logic [3:0] d,
    output logic       co_left,
    output logic       co_right,
    output logic       equ,
    output logic       zero,
    output logic       neg_zero
);

    logic [3:0] d_raw;

    // Carries come from the raw operation; COM only inverts the data nibble.
    always_comb begin
        d_raw    = 4'h0;
        co_left  = 1'b0;
        co_right = 1'b0;
        case (f)
            F_ADD:   {co_left, d_raw} = {1'b0, a} + {1'b0, b} + {4'h0, ci_right};
            F_AND:   d_raw = a & b;
            F_OR:    d_raw = a | b;
            F_XOR:   d_raw = a ^ b;
            F_PASSA: d_raw = a;
            F_PASSB: d_raw = b;
            F_SHR: begin
                d_raw    = {ci_left, a[3:1]};
                co_right = a[0];
            end
            F_SHL: begin
                d_raw   = {a[2:0], ci_right};
                co_left = a[3];
            end
            default: d_raw = 4'h0;
        endcase
    end

    assign d        = d_raw ^ {4{com}};
    assign equ      = (a == b);
    assign zero     = (d == 4'h0);
    assign neg_zero = (d == 4'hF);

endmodule

// File: rtl/tt_um_kb2ghz_xalu_seq.sv
// Purpose: 16-bit ALU built from one 4-bit slice, run one nibble per cycle.
// Latency: result/flags valid on the 4th clock edge after the accepted start edge.
// Backpressure: busy is high while running; start and operand writes are ignored then.
// Ports: ui_in operand/command byte; uio_in {start, wr, addr/readsel, unused};
//        uo_out selected result byte; uio_out {0000, zero, carry, done, busy};
//        uio_oe fixed 8'h0F; ena gates all state updates.
module tt_um_kb2ghz_xalu_seq
    import tt_um_kb2ghz_xalu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [1:0] CNT_LAST = 2'(NIBBLES - 1);

    state_t      state, state_nxt;
    logic        busy, done;
    logic [1:0]  cnt;
    cmd_t        cmd;
    logic [15:0] op_a, op_b, acc, acc_next, result;
    logic        chain, carry, zero_acc, zero_q;

    logic        start, wr;
    logic [1:0]  nib_idx;
    logic [3:0]  s_d;
    logic        s_co_left, s_co_right, s_equ, s_zero, s_neg_zero, chain_next;
    logic        last;

    assign start = uio_in[7];
    assign wr    = uio_in[6];
    assign last  = (state == ST_RUN) && (cnt == CNT_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        if (ena) begin
            case (state)
                ST_IDLE, ST_DONE: if (start) state_nxt = ST_RUN;
                ST_RUN:           if (last)  state_nxt = ST_DONE;
                default:          state_nxt = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

    // SHR walks nibbles MSB-first so the shifted-out bit feeds the next lower nibble.
    assign nib_idx    = (cmd.f == F_SHR) ? (CNT_LAST - cnt) : cnt;
    assign chain_next = (cmd.f == F_SHR) ? s_co_right : s_co_left;

    alu_slice4 u_slice (
        .a        (op_a[{nib_idx, 2'b00} +: 4]),
        .b        (op_b[{nib_idx, 2'b00} +: 4]),
        .f        (cmd.f),
        .com      (cmd.com),
        .ci_left  ((cmd.f == F_SHR) ? chain : 1'b0),
        .ci_right ((cmd.f == F_SHR) ? 1'b0 : chain),
        .d        (s_d),
        .co_left  (s_co_left),
        .co_right (s_co_right),
        .equ      (s_equ),
        .zero     (s_zero),
        .neg_zero (s_neg_zero)
    );

    always_comb begin
        acc_next = acc;
        acc_next[{nib_idx, 2'b00} +: 4] = s_d;
    end

    // Nibbles build up in acc; result/carry/zero only change when the last one lands,
    // so the previous result stays readable for the whole run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= 16'h0;
            op_b     <= 16'h0;
            cmd      <= '0;
            cnt      <= 2'd0;
            acc      <= 16'h0;
            chain    <= 1'b0;
            zero_acc <= 1'b0;
            result   <= 16'h0;
            carry    <= 1'b0;
            zero_q   <= 1'b0;
        end else if (ena) begin
            if (state != ST_RUN) begin
                if (start) begin
                    cmd      <= '{f: ui_in[2:0], com: ui_in[3], cin: ui_in[4]};
                    cnt      <= 2'd0;
                    chain    <= ui_in[4];
                    zero_acc <= 1'b1;
                end else if (wr) begin
                    case (uio_in[5:4])
                        WA_A_LO: op_a[7:0]  <= ui_in;
                        WA_A_HI: op_a[15:8] <= ui_in;
                        WA_B_LO: op_b[7:0]  <= ui_in;
                        WA_B_HI: op_b[15:8] <= ui_in;
                        default: ;
                    endcase
                end
            end else begin
                acc      <= acc_next;
                chain    <= chain_next;
                zero_acc <= zero_acc & s_zero;
                cnt      <= cnt + 2'd1;
                if (last) begin
                    result <= acc_next;
                    carry  <= chain_next;
                    zero_q <= zero_acc & s_zero;
                end
            end
        end
    end

    assign uo_out  = uio_in[4] ? result[15:8] : result[7:0];
    assign uio_out = {4'h0, zero_q, carry, done, busy};
    assign uio_oe  = 8'h0F;

    logic unused_ok;
    assign unused_ok = &{1'b0, uio_in[3:0], ui_in[7:5], s_equ, s_neg_zero, cmd.cin};

endmodule

// File: tb/tb_tt_um_kb2ghz_xalu_seq.sv
module tb_tt_um_kb2ghz_xalu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: operands and last completed result
    logic [15:0] ref_a = 16'h0, ref_b = 16'h0, ref_res = 16'h0;
    logic        ref_carry = 1'b0, ref_zero = 1'b0;

    tt_um_kb2ghz_xalu_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Whole 16-bit operation computed directly; returns {carry, result}.
    function automatic logic [16:0] ref_op(input logic [2:0] f, input logic com,
                                           input logic cin, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic        c;
        c = 1'b0;
        case (f)
            3'd0: begin s = {1'b0, a} + {1'b0, b} + 17'(cin); r = s[15:0]; c = s[16]; end
            3'd1: r = a & b;
            3'd2: r = a | b;
            3'd3: r = a ^ b;
            3'd4: r = a;
            3'd5: r = b;
            3'd6: begin r = {cin, a[15:1]}; c = a[0]; end
            default: begin r = {a[14:0], cin}; c = a[15]; end
        endcase
        if (com) r = ~r;
        return {c, r};
    endfunction

    task automatic write_byte(input logic [1:0] addr, input logic [7:0] data);
        uio_in = {2'b01, addr, 4'h0};
        ui_in  = data;
        tick();
        uio_in = 8'h00;
        ui_in  = 8'h00;
        case (addr)
            2'd0: ref_a[7:0]  = data;
            2'd1: ref_a[15:8] = data;
            2'd2: ref_b[7:0]  = data;
            default: ref_b[15:8] = data;
        endcase
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] b);
        write_byte(2'd0, a[7:0]);
        write_byte(2'd1, a[15:8]);
        write_byte(2'd2, b[7:0]);
        write_byte(2'd3, b[15:8]);
    endtask

    // Start an op, check busy/done timing, optionally poke start+wr mid-run.
    task automatic run_op(input logic [2:0] f, input logic com, input logic cin,
                          input logic inject, input logic wr_too);
        logic [16:0] r;
        logic [15:0] old_res;
        old_res = ref_res;
        uio_in = {1'b1, wr_too, 6'h0};
        ui_in  = {3'b000, cin, com, f};
        tick();
        uio_in = 8'h00;
        ui_in  = 8'h00;
        for (int i = 0; i < 4; i++) begin
            chk("busy_run", 16'(uio_out[0]), 16'h1);
            chk("done_run", 16'(uio_out[1]), 16'h0);
            if (inject && i == 1) begin
                uio_in = 8'hC0;
                ui_in  = 8'h5A;
            end
            if (inject && i == 2) chk("hold_res", 16'(uo_out), 16'(old_res[7:0]));
            tick();
            uio_in = 8'h00;
            ui_in  = 8'h00;
        end
        r = ref_op(f, com, cin, ref_a, ref_b);
        ref_res   = r[15:0];
        ref_carry = r[16];
        ref_zero  = (r[15:0] == 16'h0);
        chk("busy_done", 16'(uio_out[0]), 16'h0);
        chk("done_set", 16'(uio_out[1]), 16'h1);
    endtask

    task automatic check_result(input string tag);
        uio_in = 8'h00;
        #1;
        chk({tag, "_lo"}, 16'(uo_out), 16'(ref_res[7:0]));
        uio_in = 8'h10;
        #1;
        chk({tag, "_hi"}, 16'(uo_out), 16'(ref_res[15:8]));
        chk({tag, "_flags"}, 16'(uio_out), 16'({4'h0, ref_zero, ref_carry, 2'b10}));
        uio_in = 8'h00;
    endtask

    initial begin
        logic [2:0]  rf;
        logic        rcom, rcin;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #12;
        chk("rst_uo", 16'(uo_out), 16'h0);
        chk("rst_uio", 16'(uio_out), 16'h0);
        chk("rst_oe", 16'(uio_oe), 16'h0F);
        rst_n = 1'b1;
        tick();

        // ADD 0x12FF + 0x0001
        load(16'h12FF, 16'h0001);
        run_op(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("add1_exp", ref_res, 16'h1300);
        check_result("add1");

        // ADD with full overflow to zero
        load(16'hFFFF, 16'h0001);
        run_op(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_result("add_ovf");

        // Shifts
        load(16'h8001, 16'h0000);
        run_op(3'd6, 1'b0, 1'b1, 1'b0, 1'b0);
        check_result("shr");
        run_op(3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        check_result("shl");

        // XOR with complement, per-byte readback
        load(16'h00FF, 16'h0F0F);
        run_op(3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("xor_exp", ref_res, 16'hF00F);
        check_result("xorc");

        // ena=0: start is ignored and done holds
        ena    = 1'b0;
        uio_in = 8'h80;
        ui_in  = 8'h00;
        tick();
        uio_in = 8'h00;
        chk("ena0_busy", 16'(uio_out[0]), 16'h0);
        chk("ena0_done", 16'(uio_out[1]), 16'h1);
        ena = 1'b1;

        // Start/wr during RUN are ignored; prior result held mid-run
        load(16'h1234, 16'h4321);
        run_op(3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_result("busy_ign");
        run_op(3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        check_result("busy_opA");

        // start+wr same cycle: PASSA cmd byte 0x04 must not reach A[7:0]
        run_op(3'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        check_result("start_wr");

        // Randomised operations against the reference model
        for (int k = 0; k < 24; k++) begin
            load(16'($urandom), 16'($urandom));
            rf   = 3'($urandom_range(0, 7));
            rcom = 1'($urandom);
            rcin = 1'($urandom);
            run_op(rf, rcom, rcin, 1'b0, 1'b0);
            check_result("rand");
        end

        // Reset in the 2nd RUN cycle
        load(16'hABCD, 16'h1111);
        uio_in = 8'h80;
        ui_in  = 8'h00;
        tick();
        uio_in = 8'h00;
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_uo", 16'(uo_out), 16'h0);
        chk("midrst_uio", 16'(uio_out), 16'h0);
        uio_in = 8'h10;
        #1;
        chk("midrst_uo_hi", 16'(uo_out), 16'h0);
        uio_in = 8'h00;
        ref_a = 16'h0; ref_b = 16'h0; ref_res = 16'h0;
        ref_carry = 1'b0; ref_zero = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 16'(uio_out), 16'h0);
        run_op(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_result("post_rst_zero");
        load(16'h0001, 16'h0001);
        run_op(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_exp", ref_res, 16'h0002);
        check_result("post_rst_add");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tt_um_kb2ghz_xalu_seq.md
TT_UM_KB2GHZ_XALU_SEQ -- requirements
Module: tt_um_kb2ghz_xalu_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable
- ui_in  in  8  operand write byte, or command byte when start=1
- uo_out  out  8  selected result byte
- uio_in  in  8  [7] start, [6] wr, [5:4] write address (wr=1) / [4] read select (wr=0); [3:0] unused
- uio_out  out  8  [0] busy, [1] done, [2] carry, [3] zero; [7:4] = 0
- uio_oe  out  8  constant 8'h0F
REQ-003 Command byte fields SHALL be: ui_in[2:0] F, ui_in[3] COM, ui_in[4] cin, ui_in[7:5] ignored.
REQ-004 F encoding SHALL be: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR, 7 SHL.
REQ-005 Write addresses SHALL be: 0 A[7:0], 1 A[15:8], 2 B[7:0], 3 B[15:8].

Function
REQ-006 The block SHALL run a 16-bit operation as four sequential passes through one 4-bit ALU slice, one nibble per cycle.
REQ-007 The FSM SHALL have states IDLE, RUN, DONE, with a 2-bit nibble counter.
REQ-008 In IDLE or DONE with ena=1, start=1 SHALL latch F, COM and cin, clear the counter, clear done, and enter RUN.
REQ-009 In IDLE or DONE, wr=1 with start=0 SHALL load ui_in into the addressed operand byte.
REQ-010 If start and wr are both 1 in the same cycle, start SHALL win and the write SHALL be dropped.
REQ-011 In RUN, start and wr SHALL be ignored, and operands SHALL NOT change.
REQ-012 busy SHALL be 1 for exactly the 4 RUN cycles.
REQ-013 After the 4th RUN cycle the FSM SHALL enter DONE, with done=1 and result/flags valid 4 edges after the start edge.
REQ-014 done SHALL stay at 1 until the next accepted start.
REQ-015 Nibble order SHALL be LSB-first for F=0..5 and 7, and MSB-first for F=6.
REQ-016 Carry chaining SHALL work as follows:
- LSB-first ops: first ci_right = cin; each next ci_right = previous co_left.
- SHR: first ci_left = cin; each next ci_left = previous co_right.
REQ-017 carry SHALL be the last nibble's co_left, or co_right for SHR; it is 0 for AND/OR/XOR/PASSA/PASSB.
REQ-018 Slice semantics SHALL be:
- Result nibble = COM XOR op result.
- The carry chain is computed before COM.
- co_left is nonzero only for ADD/SHL.
- co_right is nonzero only for SHR.
REQ-019 zero SHALL be 1 when the registered 16-bit result, after COM, equals 0x0000.
REQ-020 uo_out SHALL equal result[7:0] when uio_in[4]=0 and result[15:8] when uio_in[4]=1, combinationally from the result register.
REQ-021 result, carry and zero SHALL hold their values from DONE until the next operation completes.
REQ-022 With ena=0, the FSM, counter and all registers SHALL hold their values.

Reset
REQ-023 rst_n=0 SHALL immediately, at any time including mid-RUN, force:
- state to IDLE, counter to 0
- A, B, latched command and result to 0
- busy, done, carry and zero to 0
- uo_out to 0x00
REQ-024 After reset deasserts, the first accepted start SHALL behave exactly as in REQ-008.

Structure
REQ-025 A shared package SHALL hold:
- F opcode localparams
- FSM state encoding
- write-address localparams
- the nibble count constant (4)
REQ-026 The design SHALL instantiate one combinational sub-module, alu_slice4, for the 4-bit slice.
- Inputs: A/B nibbles, F, COM, ci_left, ci_right.
- Outputs: d[3:0], co_left, co_right, EQU, ZERO, NEG_ZERO.
- The sequencer leaves EQU and NEG_ZERO unused.

Verification
REQ-027 ADD: A=0x12FF, B=0x0001, cin=0 -> result 0x1300, carry=0, zero=0; busy high exactly 4 cycles; done on the 4th edge after start.
REQ-028 ADD: A=0xFFFF, B=0x0001, cin=0 -> result 0x0000, carry=1, zero=1.
REQ-029 Shifts:
- SHR: A=0x8001, cin=1 -> result 0xC000, carry=1.
- SHL: A=0x8001, cin=0 -> result 0x0002, carry=1.
REQ-030 XOR: A=0x00FF, B=0x0F0F, COM=1 -> result 0xF00F, carry=0; read select 0/1 gives uo_out 0x0F/0xF0.
REQ-031 Busy-time inputs: start and wr during RUN are ignored, and the prior result is unaffected.
REQ-032 Same-cycle start+wr in IDLE: start runs and the write is dropped.
REQ-033 rst_n pulsed low in the 2nd RUN cycle -> all outputs 0 at once, state IDLE; a subsequent ADD 0x0001+0x0001 -> 0x0002.
